drive_arbiter: RTL and testbench

- Arbitrates the shared motor command lines (forward/backward/left/right) between the manual driver path and the autonomous obstacle-avoidance controller.
- Sits between both requesters and the motor driver.
- Grants exactly one source at a time and inserts a dead-time with all motor commands idle on every ownership change.
- Sanitises contradictory commands before they reach the motors.

---
 rtl/drive_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_drive_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/drive_arbiter.sv
// -----------------------------------------------------------------------------
// drive_arbiter
// Arbitrates the shared motor command lines between the manual driver path and
// the autonomous obstacle-avoidance controller. Exactly one source owns the
// motors at a time. Every ownership change passes through a dead-time in which
// all motor commands and grants are idle. Contradictory commands on an axis
// (fwd+bwd, left+right) are cancelled before they reach the motors.
//
// Parameters:
//   DEAD_CYCLES  cycles of forced all-stop per ownership change (1..255)
//   CNT_W        dead-time counter width, must hold DEAD_CYCLES
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   req_manual, req_auto     level ownership requests (manual has priority)
//   man_*, auto_*            motion commands from each source
//   front_detector           obstacle ahead (only with FRONT_SAFETY_STOP_EN)
//   grant_manual, grant_auto registered ownership grants
//   move_*, turn_*           registered, sanitised motor commands
//   arb_state                FSM state: IDLE=00 DEAD=01 MAN=10 AUTO=11
//   preempt_pulse            one-cycle pulse when manual preempts auto
//
// Optional feature macro: FRONT_SAFETY_STOP_EN
//   Defined   : move_forward is forced 0 whenever front_detector is 1.
//   Undefined : front_detector is ignored.
// -----------------------------------------------------------------------------
module drive_arbiter #(
    parameter int DEAD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_manual,
    input  logic       req_auto,
    input  logic       man_fwd,
    input  logic       man_bwd,
    input  logic       man_left,
    input  logic       man_right,
    input  logic       auto_fwd,
    input  logic       auto_bwd,
    input  logic       auto_left,
    input  logic       auto_right,
    input  logic       front_detector,
    output logic       grant_manual,
    output logic       grant_auto,
    output logic       move_forward,
    output logic       move_backward,
    output logic       turn_left,
    output logic       turn_right,
    output logic [1:0] arb_state,
    output logic       preempt_pulse
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_DEAD = 2'b01;
    localparam logic [1:0] ST_MAN  = 2'b10;
    localparam logic [1:0] ST_AUTO = 2'b11;

    localparam logic [1:0] TGT_NONE = 2'b00;
    localparam logic [1:0] TGT_MAN  = 2'b10;
    localparam logic [1:0] TGT_AUTO = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Command vector layout: {fwd, bwd, left, right}; each axis cancels
    // independently when both of its directions are requested.
    function automatic logic [3:0] sanitise(input logic [3:0] cmd);
        logic [3:0] res;
        res = cmd;
        if (cmd[3] && cmd[2]) begin
            res[3:2] = 2'b00;
        end else begin
            res[3:2] = cmd[3:2];
        end
        if (cmd[1] && cmd[0]) begin
            res[1:0] = 2'b00;
        end else begin
            res[1:0] = cmd[1:0];
        end
        return res;
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       target_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       state_next_s;
    logic [1:0]       target_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             preempt_s;
    logic [3:0]       cmd_s;
    logic [3:0]       motor_next_s;
    logic [3:0]       man_cmd_s;
    logic [3:0]       auto_cmd_s;

    assign man_cmd_s  = {man_fwd, man_bwd, man_left, man_right};
    assign auto_cmd_s = {auto_fwd, auto_bwd, auto_left, auto_right};

    // Next-state, target and dead-time counter logic.
    always_comb begin
        state_next_s  = state_r;
        target_next_s = target_r;
        cnt_next_s    = cnt_r;
        preempt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_manual) begin
                    target_next_s = TGT_MAN;
                    state_next_s  = ST_DEAD;
                    cnt_next_s    = '0;
                end else if (req_auto) begin
                    target_next_s = TGT_AUTO;
                    state_next_s  = ST_DEAD;
                    cnt_next_s    = '0;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_DEAD: begin
                if (req_manual && (target_r != TGT_MAN)) begin
                    // Manual arriving mid dead-time gets a full dead-time.
                    target_next_s = TGT_MAN;
                    cnt_next_s    = '0;
                end else begin
                    // A dropped target is replaced without restarting the count.
                    if ((target_r == TGT_MAN) && !req_manual) begin
                        target_next_s = req_auto ? TGT_AUTO : TGT_NONE;
                    end else if ((target_r == TGT_AUTO) && !req_auto) begin
                        target_next_s = TGT_NONE;
                    end else begin
                        target_next_s = target_r;
                    end
                    if (cnt_r == CNT_LAST) begin
                        cnt_next_s = '0;
                        case (target_next_s)
                            TGT_MAN:  state_next_s = ST_MAN;
                            TGT_AUTO: state_next_s = ST_AUTO;
                            default:  state_next_s = ST_IDLE;
                        endcase
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
            end
            ST_MAN: begin
                if (!req_manual) begin
                    target_next_s = req_auto ? TGT_AUTO : TGT_NONE;
                    state_next_s  = ST_DEAD;
                    cnt_next_s    = '0;
                end else begin
                    state_next_s  = ST_MAN;
                end
            end
            ST_AUTO: begin
                if (req_manual) begin
                    preempt_s     = 1'b1;
                    target_next_s = TGT_MAN;
                    state_next_s  = ST_DEAD;
                    cnt_next_s    = '0;
                end else if (!req_auto) begin
                    target_next_s = TGT_NONE;
                    state_next_s  = ST_DEAD;
                    cnt_next_s    = '0;
                end else begin
                    state_next_s  = ST_AUTO;
                end
            end
            default: begin
                state_next_s  = ST_IDLE;
                target_next_s = TGT_NONE;
                cnt_next_s    = '0;
            end
        endcase
    end

    // Motor command selection: only a source that owns the motors before and
    // after this edge drives them, so any ownership change idles the lines.
    always_comb begin
        cmd_s = 4'b0000;
        if ((state_r == ST_MAN) && (state_next_s == ST_MAN)) begin
            cmd_s = sanitise(man_cmd_s);
        end else if ((state_r == ST_AUTO) && (state_next_s == ST_AUTO)) begin
            cmd_s = sanitise(auto_cmd_s);
        end else begin
            cmd_s = 4'b0000;
        end
`ifdef FRONT_SAFETY_STOP_EN
        motor_next_s = {cmd_s[3] & ~front_detector, cmd_s[2:0]};
`else
        motor_next_s = cmd_s;
`endif
    end

`ifndef FRONT_SAFETY_STOP_EN
    logic unused_front_s;
    assign unused_front_s = front_detector;
`endif

    // State, target, counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            target_r      <= TGT_NONE;
            cnt_r         <= '0;
            grant_manual  <= 1'b0;
            grant_auto    <= 1'b0;
            move_forward  <= 1'b0;
            move_backward <= 1'b0;
            turn_left     <= 1'b0;
            turn_right    <= 1'b0;
            preempt_pulse <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            target_r      <= target_next_s;
            cnt_r         <= cnt_next_s;
            grant_manual  <= (state_next_s == ST_MAN);
            grant_auto    <= (state_next_s == ST_AUTO);
            move_forward  <= motor_next_s[3];
            move_backward <= motor_next_s[2];
            turn_left     <= motor_next_s[1];
            turn_right    <= motor_next_s[0];
            preempt_pulse <= preempt_s;
        end
    end

    assign arb_state = state_r;

endmodule

// File: tb/tb_drive_arbiter.sv
// -----------------------------------------------------------------------------
// tb_drive_arbiter
// Table-driven directed bench for drive_arbiter (DEAD_CYCLES=4). Each table row
// gives the inputs applied before a rising edge and the outputs expected just
// after it. Expected output vector layout:
//   {grant_manual, grant_auto, fwd, bwd, left, right, arb_state[1:0], preempt}
// A hand-written sequence covers the front-detector behaviour, whose expected
// values depend on FRONT_SAFETY_STOP_EN.
// -----------------------------------------------------------------------------
module tb_drive_arbiter;

    logic       clk;
    logic       rst;
    logic       req_manual, req_auto;
    logic       man_fwd, man_bwd, man_left, man_right;
    logic       auto_fwd, auto_bwd, auto_left, auto_right;
    logic       front_detector;
    logic       grant_manual, grant_auto;
    logic       move_forward, move_backward, turn_left, turn_right;
    logic [1:0] arb_state;
    logic       preempt_pulse;

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic       rm;
        logic       ra;
        logic [3:0] man;
        logic [3:0] aut;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    drive_arbiter #(.DEAD_CYCLES(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_manual     (req_manual),
        .req_auto       (req_auto),
        .man_fwd        (man_fwd),
        .man_bwd        (man_bwd),
        .man_left       (man_left),
        .man_right      (man_right),
        .auto_fwd       (auto_fwd),
        .auto_bwd       (auto_bwd),
        .auto_left      (auto_left),
        .auto_right     (auto_right),
        .front_detector (front_detector),
        .grant_manual   (grant_manual),
        .grant_auto     (grant_auto),
        .move_forward   (move_forward),
        .move_backward  (move_backward),
        .turn_left      (turn_left),
        .turn_right     (turn_right),
        .arb_state      (arb_state),
        .preempt_pulse  (preempt_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {grant_manual, grant_auto, move_forward, move_backward,
                turn_left, turn_right, arb_state, preempt_pulse};
    endfunction

    task automatic add(input logic r, input logic rm, input logic ra,
                       input logic [3:0] man, input logic [3:0] aut,
                       input logic gm, input logic ga, input logic [3:0] mv,
                       input logic [1:0] st, input logic pp);
        vec_t v;
        v.rst = r;
        v.rm  = rm;
        v.ra  = ra;
        v.man = man;
        v.aut = aut;
        v.exp = {gm, ga, mv, st, pp};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = outs();
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got gm,ga,fbLR,st,pp=%b required %b", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst;
        req_manual = v.rm;
        req_auto = v.ra;
        {man_fwd, man_bwd, man_left, man_right} = v.man;
        {auto_fwd, auto_bwd, auto_left, auto_right} = v.aut;
    endtask

    initial begin
        logic [3:0] fwd_blocked;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        req_manual = 1'b0;
        req_auto = 1'b0;
        {man_fwd, man_bwd, man_left, man_right} = 4'b0000;
        {auto_fwd, auto_bwd, auto_left, auto_right} = 4'b0000;
        front_detector = 1'b0;

        //   rst   rm    ra    man      auto     gm    ga    mv       st     pp
        // Reset held with both requests high, then manual wins after 4 DEAD.
        add(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        add(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        add(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b1110, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'b10, 1'b0);
        // Sanitising in MAN.
        add(1'b1, 1'b1, 1'b1, 4'b1110, 4'b0000, 1'b1, 1'b0, 4'b0010, 2'b10, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0101, 2'b10, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b1011, 4'b0000, 1'b1, 1'b0, 4'b1000, 2'b10, 1'b0);
        // Manual releases with auto pending: hand over to AUTO.
        add(1'b1, 1'b0, 1'b1, 4'b1011, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b1, 4'b0000, 2'b11, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b1, 4'b1000, 2'b11, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0110, 1'b0, 1'b1, 4'b0110, 2'b11, 1'b0);
        // Preemption by manual.
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0110, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b1);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0110, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0110, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0110, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0110, 1'b1, 1'b0, 4'b0000, 2'b10, 1'b0);
        // Both drop: DEAD with no target, then IDLE.
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        // Auto ownership from IDLE, then auto release.
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b1, 4'b0000, 2'b11, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b1, 4'b1000, 2'b11, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        // Auto request drops at DEAD cycle 2: full dead-time, back to IDLE.
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        // Manual arrives mid dead-time toward AUTO: counter restarts.
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'b10, 1'b0);
        // Reset mid-grant and mid-DEAD abort immediately.
        add(1'b0, 1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0);
        add(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Front-detector sequence: AUTO owning with fwd+left.
`ifdef FRONT_SAFETY_STOP_EN
        fwd_blocked = 4'b0010;
`else
        fwd_blocked = 4'b1010;
`endif
        req_auto = 1'b1;
        {auto_fwd, auto_bwd, auto_left, auto_right} = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        check("front_enter_auto", {1'b0, 1'b1, 4'b0000, 2'b11, 1'b0});
        @(posedge clk);
        #1;
        check("front_clear", {1'b0, 1'b1, 4'b1010, 2'b11, 1'b0});
        front_detector = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("front_blocked%0d", i), {1'b0, 1'b1, fwd_blocked, 2'b11, 1'b0});
        end
        front_detector = 1'b0;
        @(posedge clk);
        #1;
        check("front_released", {1'b0, 1'b1, 4'b1010, 2'b11, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
